// File: rtl/switch_side_rr_pkg.sv
// Shared definitions for the switch side: flit layout helpers.
// Flit = {side bit, port index[AW-1:0], data[DW-1:0]}.
package switch_side_rr_pkg;

    // Total flit width for a given port-index and payload width.
    function automatic int flit_width(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

    // LSB of the payload field.
    function automatic int dat_lsb();
        return 0;
    endfunction

    // LSB of the destination port-index field.
    function automatic int port_lsb(input int dw);
        return dw;
    endfunction

    // Position of the side bit (flit MSB).
    function automatic int side_bit(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with zero-latency head read, used as one egress queue.
// A push while full is accepted only if a pop happens in the same cycle.
module fifo_sync #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic          empty_o,
    output logic          full_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    // Qualify push/pop and compute next pointers and occupancy.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        do_pop  = pop_i & ~empty_o;
        do_push = push_i & (~full_o | do_pop);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PW'(1);
        if (do_pop)  rptr_d = rptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        // NOTE: the storage array is not reset; entries are only visible once written and counted.
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/switch_side_rr.sv
// One side of the switch: backpressure-aware round-robin arbiter over N
// device channels, a 2-stage forwarding pipeline onto the internal bus,
// and N egress FIFOs fed by the opposite side.
module switch_side_rr
    import switch_side_rr_pkg::*;
#(
    parameter int N     = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(N),
    localparam int FW   = flit_width(AW, DW),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N-1:0]      tx_valid_i,
    input  logic [N*(AW+1)-1:0] tx_adr_i,
    input  logic [N*DW-1:0]   tx_dat_i,
    output logic [N-1:0]      tx_ack_o,
    output logic [FW-1:0]     int_dat_o,
    output logic [N-1:0]      int_wen_o,
    input  logic [N-1:0]      full_i,
    input  logic [FW-1:0]     int_dat_i,
    input  logic [N-1:0]      int_wen_i,
    output logic [N-1:0]      full_o,
    output logic [N-1:0]      rx_valid_o,
    output logic [N*FW-1:0]   rx_dat_o,
    input  logic [N-1:0]      rx_ack_i,
    output logic [N-1:0]      ovf_o
);

    // Arbiter and pipeline state.
    logic [N-1:0]  gnt_q, gnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          s_vld_q, s_vld_d;
    logic [FW-1:0] s_dat_q, s_dat_d;
    logic [AW-1:0] s_dst_q, s_dst_d;
    logic [FW-1:0] int_dat_q;
    logic [N-1:0]  int_wen_q, int_wen_d;
    logic [N-1:0]  ovf_q, ovf_d;

    // Per-channel decoded request fields.
    logic [AW-1:0] dst_port [N];
    logic [FW-1:0] req_flit [N];
    logic [N-1:0]  elig;
    logic [AW-1:0] idx;
    logic          found;

    // Egress FIFO status.
    logic [N-1:0]  fifo_empty, fifo_full, pop;
    logic [CW-1:0] fifo_count [N];

    assign tx_ack_o   = gnt_q;
    assign int_dat_o  = int_dat_q;
    assign int_wen_o  = int_wen_q;
    assign ovf_o      = ovf_q;
    assign rx_valid_o = ~fifo_empty;
    assign pop        = ~fifo_empty & rx_ack_i;

    // Decode each request and decide whether it may be granted this edge.
    always_comb begin
        for (int k = 0; k < N; k++) begin
            dst_port[k] = tx_adr_i[k*(AW+1) +: AW];
            req_flit[k] = {tx_adr_i[k*(AW+1) +: AW+1], tx_dat_i[k*DW +: DW]};
            elig[k]     = tx_valid_i[k] & ~full_i[dst_port[k]] & ~gnt_q[k]
                        & ~(s_vld_q & (dst_port[k] == s_dst_q));
        end
    end

    // Round-robin pick starting at ptr, loading stage 1 with the winner.
    always_comb begin
        gnt_d   = '0;
        ptr_d   = ptr_q;
        s_vld_d = 1'b0;
        s_dat_d = s_dat_q;
        s_dst_d = s_dst_q;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && elig[ptr_q + AW'(i)]) begin
                found      = 1'b1;
                idx        = ptr_q + AW'(i);
            end
        end
        if (found) begin
            gnt_d[idx] = 1'b1;
            ptr_d      = idx + AW'(1);
            s_vld_d    = 1'b1;
            s_dat_d    = req_flit[idx];
            s_dst_d    = dst_port[idx];
        end
    end

    // Stage 2 write enable and sticky overflow flags.
    always_comb begin
        int_wen_d = '0;
        if (s_vld_q) int_wen_d[s_dst_q] = 1'b1;
        ovf_d = ovf_q | (int_wen_i & fifo_full & ~pop);
    end

    // Arbiter, pipeline and overflow registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            gnt_q     <= '0;
            ptr_q     <= '0;
            s_vld_q   <= 1'b0;
            s_dat_q   <= '0;
            s_dst_q   <= '0;
            int_dat_q <= '0;
            int_wen_q <= '0;
            ovf_q     <= '0;
        end else begin
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            s_vld_q   <= s_vld_d;
            s_dat_q   <= s_dat_d;
            s_dst_q   <= s_dst_d;
            int_dat_q <= s_dat_q;
            int_wen_q <= int_wen_d;
            ovf_q     <= ovf_d;
        end
    end

    // One egress FIFO per local port, all fed from the internal bus.
    for (genvar k = 0; k < N; k++) begin : g_egress
        fifo_sync #(
            .W     (FW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (int_wen_i[k]),
            .pop_i   (pop[k]),
            .din_i   (int_dat_i),
            .dout_o  (rx_dat_o[k*FW +: FW]),
            .empty_o (fifo_empty[k]),
            .full_o  (fifo_full[k]),
            .count_o (fifo_count[k])
        );
        assign full_o[k] = (fifo_count[k] == CW'(DEPTH));
    end

endmodule

// File: tb/tb_switch_side_rr.sv
// Self-checking bench for switch_side_rr: directed scenarios plus random
// traffic compared against a queue-based behavioural model.
module tb_switch_side_rr;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int FW    = 1 + AW + DW;

    logic              clk = 1'b0;
    logic              rst_ni;
    logic [N-1:0]      tx_valid_i;
    logic [N*(AW+1)-1:0] tx_adr_i;
    logic [N*DW-1:0]   tx_dat_i;
    logic [N-1:0]      tx_ack_o;
    logic [FW-1:0]     int_dat_o;
    logic [N-1:0]      int_wen_o;
    logic [N-1:0]      full_i;
    logic [FW-1:0]     int_dat_i;
    logic [N-1:0]      int_wen_i;
    logic [N-1:0]      full_o;
    logic [N-1:0]      rx_valid_o;
    logic [N*FW-1:0]   rx_dat_o;
    logic [N-1:0]      rx_ack_i;
    logic [N-1:0]      ovf_o;

    switch_side_rr #(.N(N), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .tx_valid_i (tx_valid_i),
        .tx_adr_i   (tx_adr_i),
        .tx_dat_i   (tx_dat_i),
        .tx_ack_o   (tx_ack_o),
        .int_dat_o  (int_dat_o),
        .int_wen_o  (int_wen_o),
        .full_i     (full_i),
        .int_dat_i  (int_dat_i),
        .int_wen_i  (int_wen_i),
        .full_o     (full_o),
        .rx_valid_o (rx_valid_o),
        .rx_dat_o   (rx_dat_o),
        .rx_ack_i   (rx_ack_i),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state.
    int              m_ptr;
    bit [N-1:0]      m_gnt;
    bit              m_svld;
    int              m_sdst;
    bit [FW-1:0]     m_sdat;
    bit [FW-1:0]     m_idat;
    bit [N-1:0]      m_wen;
    bit [N-1:0]      m_ovf;
    bit [FW-1:0]     m_q [N][$];

    function automatic int port_of(input int c);
        return int'(tx_adr_i[c*(AW+1) +: AW]);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_edge();
        int winner;
        bit do_pop;
        if (!rst_ni) begin
            m_ptr = 0; m_gnt = '0; m_svld = 0; m_sdst = 0;
            m_sdat = '0; m_idat = '0; m_wen = '0; m_ovf = '0;
            for (int k = 0; k < N; k++) m_q[k].delete();
            return;
        end
        winner = -1;
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (winner < 0 && tx_valid_i[c] && !full_i[port_of(c)] && !m_gnt[c]
                && !(m_svld && port_of(c) == m_sdst))
                winner = c;
        end
        m_idat = m_sdat;
        m_wen  = m_svld ? N'(1 << m_sdst) : '0;
        if (winner >= 0) begin
            m_svld = 1;
            m_sdst = port_of(winner);
            m_sdat = {tx_adr_i[winner*(AW+1) +: AW+1], tx_dat_i[winner*DW +: DW]};
            m_gnt  = N'(1 << winner);
            m_ptr  = (winner + 1) % N;
        end else begin
            m_svld = 0;
            m_gnt  = '0;
        end
        for (int k = 0; k < N; k++) begin
            do_pop = (m_q[k].size() > 0) && rx_ack_i[k];
            if (do_pop) void'(m_q[k].pop_front());
            if (int_wen_i[k]) begin
                if (m_q[k].size() < DEPTH) m_q[k].push_back(int_dat_i);
                else m_ovf[k] = 1;
            end
        end
    endtask

    task automatic compare_all();
        bit [N-1:0] e_full, e_vld;
        for (int k = 0; k < N; k++) begin
            e_full[k] = (m_q[k].size() == DEPTH);
            e_vld[k]  = (m_q[k].size() > 0);
        end
        check("ack", tx_ack_o, m_gnt);
        check("int_wen", int_wen_o, m_wen);
        check("int_dat", int_dat_o, m_idat);
        check("full_o", full_o, e_full);
        check("rx_valid", rx_valid_o, e_vld);
        check("ovf", ovf_o, m_ovf);
        for (int k = 0; k < N; k++)
            if (e_vld[k]) check($sformatf("rx_dat%0d", k), rx_dat_o[k*FW +: FW], m_q[k][0]);
    endtask

    // One clock: model and DUT see the same edge, outputs sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic set_ch(input int k, input bit v, input bit side, input int port, input int dat);
        tx_valid_i[k]              = v;
        tx_adr_i[k*(AW+1) +: AW+1] = {side, AW'(port)};
        tx_dat_i[k*DW +: DW]       = DW'(dat);
    endtask

    task automatic idle_inputs();
        tx_valid_i = '0; full_i = '0; int_wen_i = '0; rx_ack_i = '0; int_dat_i = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {tx_ack_o, int_wen_o, int_dat_o, rx_valid_o, full_o, ovf_o}, '0);
    endtask

    // Random device behaviour: hold until acked, then drop or present a new flit.
    task automatic random_devices();
        for (int k = 0; k < N; k++) begin
            if (tx_valid_i[k] && m_gnt[k]) begin
                if ($urandom_range(2) == 0) tx_valid_i[k] = 1'b0;
                else set_ch(k, 1'b1, 1'($urandom), $urandom_range(N-1), $urandom_range(255));
            end else if (!tx_valid_i[k] && $urandom_range(1) == 1) begin
                set_ch(k, 1'b1, 1'($urandom), $urandom_range(N-1), $urandom_range(255));
            end
        end
    endtask

    initial begin
        int n_ack;
        logic [N-1:0] prev_ack;
        tx_adr_i = '0; tx_dat_i = '0;
        idle_inputs();
        rst_ni = 1'b0;

        // Reset held with all channels requesting distinct ports.
        for (int k = 0; k < N; k++) set_ch(k, 1'b1, 1'b0, k, 8'h10 + k);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all_zero("reset_outputs");
        end
        rst_ni = 1'b1;

        // Distinct destinations: acks rotate 0..3, wen follows one cycle later.
        for (int i = 0; i < 8; i++) begin
            step();
            check("ack_seq", tx_ack_o, 64'(1 << (i % 4)));
            if (i >= 1) check("wen_seq", int_wen_o, 64'(1 << ((i - 1) % 4)));
        end

        // Two channels to the same port: grants never back to back.
        idle_inputs();
        step(); step();
        set_ch(0, 1'b1, 1'b0, 2, 8'h20);
        set_ch(1, 1'b1, 1'b1, 2, 8'h21);
        n_ack = 0; prev_ack = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            check("same_dst_b2b", 64'((prev_ack != 0) && (tx_ack_o != 0)), 64'(0));
            check("same_dst_wen", 64'((int_wen_o == 4'h0) || (int_wen_o == 4'h4)), 64'(1));
            if (tx_ack_o != 0) n_ack++;
            prev_ack = tx_ack_o;
        end
        check("same_dst_acks", n_ack, 6);

        // Destination full: no ack until full_i drops.
        idle_inputs();
        step(); step();
        full_i = 4'b1000;
        set_ch(2, 1'b1, 1'b0, 3, 8'h33);
        for (int i = 0; i < 10; i++) begin
            step();
            check("blocked_ack", tx_ack_o, 0);
        end
        full_i = '0;
        step();
        check("unblocked_ack", tx_ack_o, 4'b0100);
        idle_inputs();
        step(); step();

        // Fill egress FIFO 1, overflow with a 5th flit, then drain in order.
        int_wen_i = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            int_dat_i = {1'b0, 2'd1, 8'(8'hA0 + i)};
            step();
            if (i == 3) check("fifo1_full", full_o[1], 1);
            if (i == 3) check("fifo1_no_ovf", ovf_o[1], 0);
        end
        check("fifo1_ovf", ovf_o[1], 1);
        check("fifo1_still_full", full_o[1], 1);
        int_wen_i = '0;
        rx_ack_i  = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            check("fifo1_pop_dat", rx_dat_o[FW +: DW], 64'(8'hA0 + i));
            step();
        end
        check("fifo1_empty", rx_valid_o[1], 0);
        rx_ack_i = '0;

        // FIFO 0 full with simultaneous push and pop: stays full, no overflow.
        int_wen_i = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            int_dat_i = {1'b1, 2'd0, 8'(8'hB0 + i)};
            step();
        end
        int_dat_i = {1'b1, 2'd0, 8'hC0};
        rx_ack_i  = 4'b0001;
        step();
        check("fifo0_pp_full", full_o[0], 1);
        check("fifo0_pp_ovf", ovf_o[0], 0);
        check("fifo0_pp_head", rx_dat_o[0 +: DW], 8'hB1);

        // Reset in the middle of traffic clears everything in one edge.
        for (int k = 0; k < N; k++) set_ch(k, 1'b1, 1'b0, k, 8'h50 + k);
        int_wen_i = 4'b0100;
        rx_ack_i  = '0;
        step();
        rst_ni = 1'b0;
        step();
        check_all_zero("mid_reset");
        rst_ni = 1'b1;

        // Random traffic against the model.
        idle_inputs();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            random_devices();
            full_i    = ($urandom_range(7) == 0) ? N'($urandom) : '0;
            rx_ack_i  = N'($urandom);
            int_dat_i = FW'($urandom);
            case ($urandom_range(19))
                0:       int_wen_i = N'($urandom);
                1,2,3,4,5,6,7,8: int_wen_i = N'(1 << $urandom_range(N-1));
                default: int_wen_i = '0;
            endcase
            rst_ni = ($urandom_range(299) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
